// File: rtl/uart_pkg.sv
// Shared UART transmit types and constants.
// Optional parity stage: UART_TX_PARITY_EN.
package uart_pkg;

    localparam int   DATA_BITS        = 8;
    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    function automatic logic even_parity(
        input logic [DATA_BITS-1:0] b
    );
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Byte write handshake into the UART transmitter.
// Master drives data/valid, slave returns ready.
interface uart_tx_framer_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO for the UART transmitter.
// Depth must be a power of two so pointers wrap naturally.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          uart_clk_rx,
    input  logic                          RST_n,
    input  logic                          push,
    input  logic [DATA_BITS-1:0]          din,
    input  logic                          pop,
    output logic [DATA_BITS-1:0]          dout,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 push_ok;
    logic                 pop_ok;

    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge uart_clk_rx) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge uart_clk_rx) begin
        if (!RST_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// Buffered UART transmitter, one clock edge per serial bit.
// Define UART_TX_PARITY_EN to add an even parity bit.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                        uart_clk_rx,
    input  logic                        RST_n,
    uart_tx_framer_if.slave             tx_if,
    output logic                        uart_tx_data,
    output logic                        tx_busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [1:0]           stop_cnt_q, stop_cnt_d;
    logic                 line_q, line_d;
    logic                 done_q, done_d;
    logic                 pop;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [1:0] LAST_STOP = 2'(STOP_BITS - 1);
    localparam logic       ONE_STOP  = (STOP_BITS == 1);

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .uart_clk_rx (uart_clk_rx),
        .RST_n       (RST_n),
        .push        (tx_if.tx_valid),
        .din         (tx_if.tx_data),
        .pop         (pop),
        .dout        (fifo_dout),
        .level       (fifo_level),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    assign tx_if.tx_ready = !fifo_full;
    assign uart_tx_data   = line_q;
    assign tx_done        = done_q;
    assign tx_busy        = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        line_d     = line_q;
        done_d     = 1'b0;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                line_d = UART_IDLE_LEVEL;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_dout;
                    bit_cnt_d = '0;
                    state_d   = START;
                    line_d    = UART_START_LEVEL;
`ifdef UART_TX_PARITY_EN
                    par_d     = even_parity(fifo_dout);
`endif
                end
            end
            START: begin
                state_d   = DATA;
                bit_cnt_d = '0;
                line_d    = shift_q[0];
            end
            DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                    state_d    = PARITY;
                    line_d     = par_q;
`else
                    state_d    = STOP;
                    stop_cnt_d = '0;
                    line_d     = UART_IDLE_LEVEL;
                    done_d     = ONE_STOP;
`endif
                end else begin
                    shift_d   = shift_q >> 1;
                    line_d    = shift_q[1];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                state_d    = STOP;
                stop_cnt_d = '0;
                line_d     = UART_IDLE_LEVEL;
                done_d     = ONE_STOP;
            end
`endif
            STOP: begin
                if (stop_cnt_q == LAST_STOP) begin
                    // Back-to-back frames: no idle bit between them.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = fifo_dout;
                        bit_cnt_d = '0;
                        state_d   = START;
                        line_d    = UART_START_LEVEL;
`ifdef UART_TX_PARITY_EN
                        par_d     = even_parity(fifo_dout);
`endif
                    end else begin
                        state_d = IDLE;
                        line_d  = UART_IDLE_LEVEL;
                    end
                end else begin
                    stop_cnt_d = stop_cnt_q + 2'd1;
                    line_d     = UART_IDLE_LEVEL;
                    done_d     = (stop_cnt_d == LAST_STOP);
                end
            end
            default: begin
                state_d = IDLE;
                line_d  = UART_IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge uart_clk_rx) begin
        if (!RST_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            line_q     <= UART_IDLE_LEVEL;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            line_q     <= line_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer (1 and 2 stop bits).
// Honours UART_TX_PARITY_EN for the expected frame shape.
module tb_uart_tx_framer;
    import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL1 = 1 + 8 + PAR + 1;
    localparam int FL2 = 1 + 8 + PAR + 2;

    logic       uart_clk_rx = 1'b0;
    logic       RST_n = 1'b0;
    logic       line1, busy1, done1;
    logic       line2, busy2, done2;
    logic [2:0] lvl1, lvl2;
    logic       par_seen;

    int errs   = 0;
    int checks = 0;

    always #5 uart_clk_rx = ~uart_clk_rx;

    uart_tx_framer_if if1 ();
    uart_tx_framer_if if2 ();

    uart_tx_framer #(
        .FIFO_DEPTH (4),
        .STOP_BITS  (1)
    ) u_dut (
        .uart_clk_rx  (uart_clk_rx),
        .RST_n        (RST_n),
        .tx_if        (if1),
        .uart_tx_data (line1),
        .tx_busy      (busy1),
        .tx_done      (done1),
        .fifo_level   (lvl1)
    );

    uart_tx_framer #(
        .FIFO_DEPTH (4),
        .STOP_BITS  (2)
    ) u_dut2 (
        .uart_clk_rx  (uart_clk_rx),
        .RST_n        (RST_n),
        .tx_if        (if2),
        .uart_tx_data (line2),
        .tx_busy      (busy2),
        .tx_done      (done2),
        .fifo_level   (lvl2)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic fbit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (PAR == 1 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge uart_clk_rx);
        #1;
    endtask

    // Current sample must already be bit 0 (start) of the frame.
    task automatic run_frame(input int which, input logic [7:0] b,
                             input string tag);
        int   fl;
        logic ln, dn, bs;
        fl = (which == 1) ? FL1 : FL2;
        for (int i = 0; i < fl; i++) begin
            if (i > 0) step();
            ln = (which == 1) ? line1 : line2;
            dn = (which == 1) ? done1 : done2;
            bs = (which == 1) ? busy1 : busy2;
            if (PAR == 1 && i == 9) par_seen = ln;
            chk($sformatf("%s_bit%0d", tag, i), ln, fbit(b, i));
            chk($sformatf("%s_done%0d", tag, i), dn, (i == fl - 1));
            chk($sformatf("%s_busy%0d", tag, i), bs, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int   acc;
        int   zeros;
        logic rdy, vld;
        par_seen     = 1'b0;
        if1.tx_valid = 1'b0;
        if1.tx_data  = 8'h00;
        if2.tx_valid = 1'b0;
        if2.tx_data  = 8'h00;
        RST_n = 1'b0;
        step();
        step();
        chk("rst_line", line1, 1);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_ready", if1.tx_ready, 1);
        chk("rst_level", lvl1, 0);
        chk("rst_line2", line2, 1);
        RST_n = 1'b1;
        step();

        // Single byte 0x55
        if1.tx_data  = 8'h55;
        if1.tx_valid = 1'b1;
        step();
        if1.tx_valid = 1'b0;
        chk("t1_level", lvl1, 1);
        chk("t1_pre_line", line1, 1);
        step();
        run_frame(1, 8'h55, "t1");
`ifdef UART_TX_PARITY_EN
        chk("t1_par55", par_seen, 0);
`endif
        step();
        chk("t1_idle_line", line1, 1);
        chk("t1_idle_busy", busy1, 0);
        chk("t1_idle_done", done1, 0);
        chk("t1_idle_level", lvl1, 0);

        // Back-to-back 0xA5, 0x3C
        if1.tx_data  = 8'hA5;
        if1.tx_valid = 1'b1;
        step();
        if1.tx_data  = 8'h3C;
        step();
        if1.tx_valid = 1'b0;
        chk("t2_level", lvl1, 1);
        run_frame(1, 8'hA5, "t2a");
        step();
        run_frame(1, 8'h3C, "t2b");
        step();
        chk("t2_idle_line", line1, 1);
        chk("t2_idle_busy", busy1, 0);

        // Hold valid: 1 in flight plus 4 buffered
        acc          = 0;
        if1.tx_data  = 8'h10;
        if1.tx_valid = 1'b1;
        for (int t = 0; t < 1 + 5 * FL1; t++) begin
            rdy = if1.tx_ready;
            vld = if1.tx_valid;
            step();
            if (rdy && vld) begin
                acc++;
                if1.tx_data = 8'(8'h10 + acc);
            end
            if (t == 7) if1.tx_valid = 1'b0;
            if (t == 4) begin
                chk("t3_full_level", lvl1, 4);
                chk("t3_full_ready", if1.tx_ready, 0);
            end
            if (t >= 1) begin
                int u, f, idx;
                u   = t - 1;
                f   = u / FL1;
                idx = u % FL1;
                chk($sformatf("t3_f%0d_bit%0d", f, idx), line1,
                    fbit(8'(8'h10 + f), idx));
                chk($sformatf("t3_f%0d_done%0d", f, idx), done1,
                    (idx == FL1 - 1));
            end
        end
        chk("t3_accepted", acc, 5);
        step();
        chk("t3_idle_busy", busy1, 0);
        chk("t3_idle_line", line1, 1);
        chk("t3_idle_level", lvl1, 0);

        // Reset during data bit 3 of 0xFF with 2 bytes buffered
        if1.tx_data  = 8'hFF;
        if1.tx_valid = 1'b1;
        step();
        if1.tx_data  = 8'h11;
        step();
        if1.tx_data  = 8'h22;
        step();
        if1.tx_valid = 1'b0;
        step();
        step();
        step();
        chk("t4_bit3", line1, 1);
        chk("t4_level", lvl1, 2);
        chk("t4_busy", busy1, 1);
        RST_n = 1'b0;
        step();
        chk("t4_rst_line", line1, 1);
        chk("t4_rst_level", lvl1, 0);
        chk("t4_rst_busy", busy1, 0);
        chk("t4_rst_done", done1, 0);
        chk("t4_rst_ready", if1.tx_ready, 1);
        RST_n = 1'b1;
        zeros = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (line1 == 1'b0 || busy1 == 1'b1) zeros++;
        end
        chk("t4_quiet", zeros, 0);

        // Two stop bits, byte 0x00
        if2.tx_data  = 8'h00;
        if2.tx_valid = 1'b1;
        step();
        if2.tx_valid = 1'b0;
        step();
        run_frame(2, 8'h00, "t5");
        step();
        chk("t5_idle_line", line2, 1);
        chk("t5_idle_busy", busy2, 0);
        chk("t5_idle_done", done2, 0);

`ifdef UART_TX_PARITY_EN
        if1.tx_data  = 8'h07;
        if1.tx_valid = 1'b1;
        step();
        if1.tx_valid = 1'b0;
        step();
        run_frame(1, 8'h07, "t6");
        chk("t6_par07", par_seen, 1);
        step();
        chk("t6_idle_busy", busy1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
Serial UART transmitter that pairs with the existing bit-rate UART receiver. It runs on the same one-tick-per-bit clock and buffers bytes in a small FIFO. It serialises each byte as one start bit (0), 8 data bits LSB first, and STOP_BITS stop bits (1). It sits between the ADC sample formatter and the board TX pin.

Parameters:
DATA_BITS, 8, payload bits per frame (fixed at 8; not to be overridden)
FIFO_DEPTH, 4, byte buffer entries; must be a power of two, 2..16
STOP_BITS, 1, number of stop bits; legal values are 1 or 2

Ports:
uart_clk_rx  in  1  bit-rate clock; one rising edge per serial bit
RST_n  in  1  synchronous, active-low reset
tx_data  in  8  byte to send
tx_valid  in  1  write request; accepted on an edge where tx_valid && tx_ready
tx_ready  out  1  FIFO not full
uart_tx_data  out  1  serial line output, registered, idles high
tx_busy  out  1  high while a frame is being driven, start through last stop bit
tx_done  out  1  one-cycle pulse while the last stop bit of a frame is driven
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset and clock: reset RST_n, synchronous, active-low; clock uart_clk_rx.
- Reset values (on any edge with RST_n=0, including mid-frame):
  - uart_tx_data=1, tx_busy=0, tx_done=0, tx_ready=1, fifo_level=0.
  - FSM returns to IDLE; FIFO pointers are cleared; any partial frame is abandoned.
- FIFO write:
  - An edge with tx_valid && tx_ready writes tx_data and increments the level.
  - tx_ready = (fifo_level != FIFO_DEPTH), derived from registered state only; there is no same-cycle bypass.
  - A write attempted while full is ignored.
- FIFO pop: occurs only in IDLE, or on the final stop-bit cycle, on an edge where fifo_level != 0.
  - Simultaneous push and pop leaves the level unchanged and stores the data correctly.
  - A push into an empty FIFO is not popped on the same edge.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> (START | IDLE).
  - IDLE: line=1. If the FIFO is non-empty at an edge: pop into the shift register, enter START, drive line=0 from that edge.
  - START: one cycle, then DATA with bit index 0.
  - DATA: line = shift[0]; shift right each edge; after 8 cycles go to PARITY (if compiled in) or STOP.
  - STOP: line=1 for STOP_BITS cycles; tx_done=1 on the last one.
  - At the end of STOP: if the FIFO is non-empty, pop and go straight to START with no idle gap; otherwise go to IDLE.
- Timing:
  - Latency: a write at edge k into an empty FIFO with the FSM in IDLE gives a start bit driven from edge k+1.
  - Frame length is 1+8+STOP_BITS cycles (+1 with parity).
- tx_busy=1 in START, DATA, PARITY and STOP.
- fifo_level wraps never: it is saturated by construction through the tx_ready gating.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state of one cycle is inserted after the data bits.
  - It carries even parity: the XOR of the 8 data bits.
  - Frame length becomes 11 cycles with STOP_BITS=1.
- Undefined: no PARITY state and no parity logic; frame length is 10 cycles.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP.
  - UART_IDLE_LEVEL=1, UART_START_LEVEL=0.
  - DATA_BITS constant.
- Sub-module uart_tx_fifo: synchronous FIFO with push/pop/level, parameterised by FIFO_DEPTH, same clock and reset.
- The FSM and shift register live in uart_tx_framer.

Test Plan:
- Reset, then write 0x55 once -> line sequence from edge k+1 is 0,1,0,1,0,1,0,1,0,1; tx_done pulses on the 10th bit; line then stays 1 and tx_busy=0.
- Write 0xA5 and 0x3C on consecutive edges -> 20 contiguous bit-cycles (0,1,0,1,0,0,1,0,1,1 then 0,0,0,1,1,1,1,0,0,1) with no idle gap; tx_done pulses twice.
- Hold tx_valid high with FIFO_DEPTH=4 while a frame is in flight -> tx_ready falls when fifo_level=4; extra writes are dropped; after all frames drain, exactly 5 bytes have been sent (1 in flight plus 4 buffered).
- Assert RST_n=0 during data bit 3 of 0xFF with 2 bytes buffered -> on the next edge the line is 1, fifo_level=0, tx_busy=0; nothing is transmitted after release.
- STOP_BITS=2, write 0x00 -> 0 x9 then 1 x2; tx_done is on the second stop cycle.
- With UART_TX_PARITY_EN defined: write 0x07 -> parity bit 1; write 0x55 -> parity bit 0; frame length is 11 cycles.
